// File: rtl/conv_row_accumulator.sv
// conv_row_accumulator: sums K consecutive beats of LANES signed partial sums into one
// output row, clamps each lane to unsigned 8 bits and hands the row to the line RAM on a
// single-entry valid/ready register. Owns frame row counting and the conv_done pulse.
// Optional feature macro: CONV_ACC_BIAS_EN adds a signed per-row bias input.
module conv_row_accumulator #(
    parameter int unsigned LANES  = 128,
    parameter int unsigned IN_W   = 20,
    parameter int unsigned K      = 3,
    parameter int unsigned ROWS   = 128,
    parameter int unsigned ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
`ifdef CONV_ACC_BIAS_EN
    input  logic signed [IN_W-1:0] bias,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*8-1:0]     out_data,
    output logic [ADDR_W-1:0]      out_addr,
    output logic                   busy,
    output logic                   conv_done
);

    // One spare bit beyond the K-beat growth keeps the bias add from wrapping.
    localparam int unsigned ACC_W = IN_W + $clog2(K) + 1;
    localparam int unsigned TAP_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [TAP_W-1:0]        TapLast = TAP_W'(K - 1);
    localparam logic [ADDR_W-1:0]       RowLast = ADDR_W'(ROWS - 1);
    localparam logic signed [ACC_W-1:0] PixMax  = ACC_W'(255);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e                  state_q;
    logic [TAP_W-1:0]        tap_q;
    logic [ADDR_W-1:0]       row_cnt_q;
    logic signed [ACC_W-1:0] acc_q [LANES];

    logic signed [ACC_W-1:0] sum [LANES];
    logic signed [ACC_W-1:0] bias_ext;
    logic [LANES*8-1:0]      clamped;
    logic                    last_tap;
    logic                    accept;
    logic                    out_hs;

    function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] v);
        if (v[ACC_W-1]) begin
            return 8'h00;
        end else if (v > PixMax) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

`ifdef CONV_ACC_BIAS_EN
    assign bias_ext = {{(ACC_W-IN_W){bias[IN_W-1]}}, bias};
`else
    assign bias_ext = '0;
`endif

    // Per-lane running sum: the tap-0 beat (plus bias) restarts the row, later beats add.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [IN_W-1:0]  lane;
        logic signed [ACC_W-1:0] lane_ext;

        assign lane     = in_data[IN_W*g +: IN_W];
        assign lane_ext = {{(ACC_W-IN_W){lane[IN_W-1]}}, lane};
        assign sum[g]   = (tap_q == '0) ? lane_ext + bias_ext : acc_q[g] + lane_ext;
        assign clamped[8*g +: 8] = clamp8(sum[g]);
    end

    assign last_tap = (tap_q == TapLast);
    assign out_hs   = out_valid && out_ready;
    // Only the final tap can stall, and only while the output register stays occupied.
    assign in_ready = (state_q == StRun) && !(last_tap && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != StIdle);
    // Pulses on the cycle the last row leaves, which is also the DRAIN -> IDLE edge.
    assign conv_done = (state_q == StDrain) && (!out_valid || out_ready);

    // Frame FSM, tap/row counters, accumulator and the single-entry output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            tap_q     <= '0;
            row_cnt_q <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (accept && last_tap) begin
                out_valid <= 1'b1;
                out_data  <= clamped;
                out_addr  <= row_cnt_q;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                for (int i = 0; i < LANES; i++) begin
                    acc_q[i] <= sum[i];
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StRun;
                        tap_q     <= '0;
                        row_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (last_tap) begin
                            tap_q     <= '0;
                            row_cnt_q <= row_cnt_q + 1'b1;
                            if (row_cnt_q == RowLast) begin
                                state_q <= StDrain;
                            end
                        end else begin
                            tap_q <= tap_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (conv_done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_accumulator.sv
// Scoreboard bench for conv_row_accumulator: the driver feeds beats into a plain-arithmetic
// row model that pushes expected rows; a negedge monitor compares every presented row.
module tb_conv_row_accumulator;

    localparam int LANES  = 4;
    localparam int IN_W   = 20;
    localparam int K      = 3;
    localparam int ROWS   = 2;
    localparam int ADDR_W = 1;
    localparam int IN_MIN = -(1 << (IN_W - 1));
    localparam int IN_MAX = (1 << (IN_W - 1)) - 1;

    typedef int beat_t [LANES];
    typedef struct {
        logic [LANES*8-1:0] data;
        logic [ADDR_W-1:0]  addr;
    } row_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LANES*IN_W-1:0] in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [LANES*8-1:0]    out_data;
    logic [ADDR_W-1:0]     out_addr;
    logic                  busy;
    logic                  conv_done;
`ifdef CONV_ACC_BIAS_EN
    logic signed [IN_W-1:0] bias = '0;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
    int   bias_v = 0;
    row_t sb[$];
    int   hs_cycles[$];

    // Reference model state: plain per-lane sums of the beats of the current row.
    longint acc_m [LANES];
    int     tap_m = 0;
    int     row_m = 0;

    conv_row_accumulator #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .K     (K),
        .ROWS  (ROWS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef CONV_ACC_BIAS_EN
        .bias     (bias),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr),
        .busy     (busy),
        .conv_done(conv_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] clamp_ref(input longint s);
        if (s < 0) return 8'h00;
        if (s > 255) return 8'hFF;
        return 8'(s);
    endfunction

    function automatic int rand_lane();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, (1 << IN_W) - 1)) + IN_MIN;
        return int'($urandom_range(0, 460)) - 150;
    endfunction

    task automatic set_bias(input int b);
        bias_v = b;
`ifdef CONV_ACC_BIAS_EN
        bias = IN_W'(b);
`endif
    endtask

    // Model: a row is the clamped lane-wise sum of K beats, bias added once per row.
    task automatic model_accept(input beat_t v);
        row_t r;
        for (int i = 0; i < LANES; i++) begin
            if (tap_m == 0) acc_m[i] = longint'(v[i]) + bias_v;
            else acc_m[i] = acc_m[i] + v[i];
        end
        tap_m++;
        if (tap_m == K) begin
            for (int i = 0; i < LANES; i++) r.data[8*i +: 8] = clamp_ref(acc_m[i]);
            r.addr = ADDR_W'(row_m);
            sb.push_back(r);
            row_m++;
            tap_m = 0;
        end
    endtask

    // out_ready driver, updated just after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every presented row must match the scoreboard head; pop on handshake.
    bit hs;
    bit exp_done;
    always @(negedge clk) begin
        if (!reset) begin
            hs = out_valid && out_ready;
            exp_done = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: got addr %0d data 0x%0h, expected none",
                             out_addr, out_data);
                end else begin
                    check("out_data", longint'(out_data), longint'(sb[0].data));
                    check("out_addr", longint'(out_addr), longint'(sb[0].addr));
                    exp_done = hs && (sb[0].addr == ADDR_W'(ROWS - 1));
                    if (hs) begin
                        void'(sb.pop_front());
                        hs_cycles.push_back(cyc);
                    end
                end
            end
            check("conv_done", longint'(conv_done), longint'(exp_done));
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input beat_t v);
        int n = 0;
        bit ok = 0;
        for (int i = 0; i < LANES; i++) in_data[IN_W*i +: IN_W] = IN_W'(v[i]);
        in_valid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, expected 1", n);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(v);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_same(input int a, input int b, input int c, input int d);
        beat_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        send_beat(v);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        tap_m = 0;
        row_m = 0;
        @(negedge clk);
        check("busy_after_start", longint'(busy), 1);
        check("in_ready_after_start", longint'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        bit seen = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            if (conv_done) seen = 1;
            else n++;
        end
        check("conv_done_seen", longint'(seen), 1);
        check("busy_at_done", longint'(busy), 1);
        @(negedge clk);
        check("conv_done_one_cycle", longint'(conv_done), 0);
        check("busy_after_done", longint'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, longint'(in_ready), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_out_data"}, longint'(out_data), 0);
        check({tag, "_out_addr"}, longint'(out_addr), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_conv_done"}, longint'(conv_done), 0);
    endtask

    initial begin
        beat_t v;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Beats outside RUN are ignored.
        send_dummy_idle();

        // Basic frame: {10,20,30,40} x3 then a boundary row.
        ready_mode = 1;
        do_start();
        repeat (K) send_same(10, 20, 30, 40);
        @(negedge clk);
        check("latency_out_valid", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        send_same(0, 85, 100, -1);
        send_same(0, 85, 100, 0);
        send_same(0, 85, 56, 0);
        wait_done();
        send_dummy_idle();

        // Backpressure frame with max-magnitude inputs and clamp boundaries.
        ready_mode = 0;
        do_start();
        send_same(IN_MIN, IN_MAX, IN_MIN, IN_MIN);
        send_same(IN_MIN, IN_MAX, IN_MAX, IN_MAX);
        send_same(IN_MIN, IN_MAX, 256, 200);
        send_same(-100, 200, 100, 100);
        send_same(-50, 50, 100, 100);
        @(negedge clk);
        check("held_out_valid", longint'(out_valid), 1);
        hs_cycles.delete();
        v[0] = 20; v[1] = 10; v[2] = 55; v[3] = 54;
        fork
            send_beat(v);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("in_ready_stalled", longint'(in_ready), 0);
                end
                ready_mode = 1;
            end
        join
        wait_done();
        check("handoff_count", longint'(hs_cycles.size()), 2);
        if (hs_cycles.size() == 2)
            check("handoff_consecutive", longint'(hs_cycles[1] - hs_cycles[0]), 1);

        // Reset mid-row discards the partial sum.
        do_start();
        send_same(7, 7, 7, 7);
        send_same(7, 7, 7, 7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        tap_m = 0;
        row_m = 0;
        @(negedge clk);
        check_reset_vals("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        do_start();
        repeat (K) send_same(1, 1, 1, 1);
        repeat (K) send_same(rand_lane(), rand_lane(), rand_lane(), rand_lane());
        wait_done();

`ifdef CONV_ACC_BIAS_EN
        ready_mode = 1;
        do_start();
        set_bias(-5);
        repeat (K) send_same(2, 2, 2, 2);
        set_bias(-10);
        repeat (K) send_same(2, 2, 2, 2);
        wait_done();
        set_bias(0);
`endif

        // Random frames with random backpressure and input gaps.
        ready_mode = 2;
        for (int f = 0; f < 12; f++) begin
            do_start();
            for (int r = 0; r < ROWS; r++) begin
`ifdef CONV_ACC_BIAS_EN
                set_bias(int'($urandom_range(0, 200)) - 100);
`endif
                for (int t = 0; t < K; t++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                    for (int i = 0; i < LANES; i++) v[i] = rand_lane();
                    send_beat(v);
                end
            end
            wait_done();
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Drive in_valid while the block is idle: it must not be taken nor make a row.
    task automatic send_dummy_idle();
        for (int i = 0; i < LANES; i++) in_data[IN_W*i +: IN_W] = IN_W'(i + 5);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", longint'(in_ready), 0);
            check("idle_out_valid", longint'(out_valid), 0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

endmodule
